// File: rtl/cmp_sort_ctrl.sv
// Block sorter: loads DEPTH words, bubble-sorts them through an external
// comparator one compare/swap per cycle, then streams them out ascending.
module cmp_sort_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_greater,
  input  logic             cmp_equal,
  input  logic             cmp_lesser,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             sort_done,
  output logic             cmp_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST  = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PLAST = PW'(DEPTH - 2);

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } state_t;

  state_t state;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] idx_nx;
  logic [PW-1:0] pass;
  logic swapped;

  logic beat;
  logic swap_we;
  logic pass_end;
  logic any_swap;
  logic onehot;
  logic in_sort;

  assign in_sort  = (state == SORT);
  assign idx_nx   = idx + PW'(1);
  assign beat     = (state == LOAD) & in_valid & ~flush;
  assign swap_we  = in_sort & cmp_greater & ~flush;
  assign pass_end = (idx == PLAST - pass);
  assign any_swap = swapped | cmp_greater;
  assign onehot   = $onehot({cmp_greater, cmp_equal, cmp_lesser});

  assign cmp_a    = in_sort ? mem[idx]    : mem[0];
  assign cmp_b    = in_sort ? mem[idx_nx] : mem[1];
  assign out_data = mem[rd_ptr];

  // Storage is not reset; its contents are meaningless until a block loads.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem[wr_ptr] <= in_data;
    end else if (swap_we) begin
      mem[idx]    <= mem[idx_nx];
      mem[idx_nx] <= mem[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      idx       <= '0;
      pass      <= '0;
      swapped   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      sort_done <= 1'b0;
      cmp_err   <= 1'b0;
    end else begin
      sort_done <= 1'b0;
      if (in_sort && !onehot) begin
        cmp_err <= 1'b1;
      end
      if (flush) begin
        state     <= LOAD;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        idx       <= '0;
        pass      <= '0;
        swapped   <= 1'b0;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          LOAD: begin
            if (in_valid) begin
              if (wr_ptr == LAST) begin
                state    <= SORT;
                wr_ptr   <= '0;
                in_ready <= 1'b0;
                busy     <= 1'b1;
                idx      <= '0;
                pass     <= '0;
                swapped  <= 1'b0;
              end else begin
                wr_ptr <= wr_ptr + PW'(1);
              end
            end
          end
          SORT: begin
            if (pass_end) begin
              // A clean pass proves the block is ordered.
              if (!any_swap || pass == PLAST) begin
                state     <= DRAIN;
                busy      <= 1'b0;
                sort_done <= 1'b1;
                out_valid <= 1'b1;
                out_last  <= 1'b0;
                rd_ptr    <= '0;
                pass      <= '0;
              end else begin
                pass <= pass + PW'(1);
              end
              idx     <= '0;
              swapped <= 1'b0;
            end else begin
              idx     <= idx_nx;
              swapped <= any_swap;
            end
          end
          DRAIN: begin
            if (out_ready) begin
              if (rd_ptr == LAST) begin
                state     <= LOAD;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                in_ready  <= 1'b1;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
              end else begin
                rd_ptr   <= rd_ptr + PW'(1);
                out_last <= (rd_ptr == LAST - PW'(1));
              end
            end
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

endmodule
